// File: rtl/kl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kl_pkg
// Brief    : KL bus field widths, request record and arbiter FSM encoding.
// Revision : 1.0
// ============================================================================
package kl_pkg;

   localparam int KL_ADDR_W = 32;
   localparam int KL_DATA_W = 64;
   localparam int KL_MASK_W = 8;
   localparam int KL_SIZE_W = 3;
   localparam int KL_ID_W   = 5;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } kl_state_e;

   // 113 bits: everything the downstream request carries except valid
   typedef struct packed {
      logic [KL_ADDR_W-1:0] addr;
      logic                 wen;
      logic [KL_DATA_W-1:0] wdata;
      logic [KL_MASK_W-1:0] wmask;
      logic [KL_SIZE_W-1:0] size;
      logic [KL_ID_W-1:0]   srcid;
   } kl_req_t;

endpackage
`default_nettype wire

// File: rtl/kl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : kl_rr_arb2
// Brief    : Two-way round-robin grant from an eligible vector and last grant.
// Revision : 1.0
// ============================================================================
module kl_rr_arb2 (
   input  logic [1:0] i_eligible,
   input  logic       i_last_grant,
   output logic [1:0] o_grant,
   output logic       o_grant_idx
);

   always_comb begin
      o_grant = 2'b00;
      case (i_eligible)
         2'b01:   o_grant = 2'b01;
         2'b10:   o_grant = 2'b10;
         // On a tie the master that did not win last time goes first
         2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
         default: o_grant = 2'b00;
      endcase
   end

   assign o_grant_idx = o_grant[1];

endmodule
`default_nettype wire

// File: rtl/kl_arb2.sv
`default_nettype none
// ============================================================================
// Module   : kl_arb2
// Brief    : Two-master KL request arbiter with one outstanding request per
//            master and dstid-based response routing.
// Revision : 1.0
// ============================================================================
module kl_arb2
   import kl_pkg::*;
#(
   parameter logic [KL_ID_W-1:0] SRCID0 = 5'd0,
   parameter logic [KL_ID_W-1:0] SRCID1 = 5'd1
) (
   input  logic                 clk,
   input  logic                 rst,

   input  logic [KL_ADDR_W-1:0] m0_req_addr,
   input  logic                 m0_req_wen,
   input  logic [KL_DATA_W-1:0] m0_req_wdata,
   input  logic [KL_MASK_W-1:0] m0_req_wmask,
   input  logic [KL_SIZE_W-1:0] m0_req_size,
   input  logic                 m0_req_valid,
   output logic                 m0_req_ready,
   output logic [KL_DATA_W-1:0] m0_resp_rdata,
   output logic                 m0_resp_ren,
   output logic [KL_SIZE_W-1:0] m0_resp_size,
   output logic                 m0_resp_valid,
   input  logic                 m0_resp_ready,

   input  logic [KL_ADDR_W-1:0] m1_req_addr,
   input  logic                 m1_req_wen,
   input  logic [KL_DATA_W-1:0] m1_req_wdata,
   input  logic [KL_MASK_W-1:0] m1_req_wmask,
   input  logic [KL_SIZE_W-1:0] m1_req_size,
   input  logic                 m1_req_valid,
   output logic                 m1_req_ready,
   output logic [KL_DATA_W-1:0] m1_resp_rdata,
   output logic                 m1_resp_ren,
   output logic [KL_SIZE_W-1:0] m1_resp_size,
   output logic                 m1_resp_valid,
   input  logic                 m1_resp_ready,

   output logic [KL_ADDR_W-1:0] bus_req_addr,
   output logic                 bus_req_wen,
   output logic [KL_DATA_W-1:0] bus_req_wdata,
   output logic [KL_MASK_W-1:0] bus_req_wmask,
   output logic [KL_SIZE_W-1:0] bus_req_size,
   output logic [KL_ID_W-1:0]   bus_req_srcid,
   output logic                 bus_req_valid,
   input  logic                 bus_req_ready,

   input  logic [KL_DATA_W-1:0] bus_resp_rdata,
   input  logic                 bus_resp_ren,
   input  logic [KL_SIZE_W-1:0] bus_resp_size,
   input  logic [KL_ID_W-1:0]   bus_resp_dstid,
   input  logic                 bus_resp_valid,
   output logic                 bus_resp_ready,

   output logic                 err_dstid
);

   kl_state_e  r_state;
   kl_state_e  w_state_nxt;
   logic [1:0] r_pend;
   logic       r_last_grant;
   logic       r_err_dstid;
   kl_req_t    r_req;

   logic [1:0] w_eligible;
   logic [1:0] w_arb_grant;
   logic       w_arb_idx;
   logic [1:0] w_grant;
   kl_req_t    w_sel_req;

   logic       w_hit0;
   logic       w_hit1;
   logic       w_resp_hs;
   logic [1:0] w_resp_clr;
   logic       w_resp_bad;

   // ------------------------------------------------------------------
   // Request arbitration
   // ------------------------------------------------------------------
   assign w_eligible = {m1_req_valid & ~r_pend[1], m0_req_valid & ~r_pend[0]};

   kl_rr_arb2 u_rr_arb2 (
      .i_eligible   (w_eligible),
      .i_last_grant (r_last_grant),
      .o_grant      (w_arb_grant),
      .o_grant_idx  (w_arb_idx)
   );

   assign w_grant      = (r_state == ST_IDLE && !rst) ? w_arb_grant : 2'b00;
   assign m0_req_ready = w_grant[0];
   assign m1_req_ready = w_grant[1];

   always_comb begin
      w_sel_req = '0;
      if (w_arb_idx) begin
         w_sel_req.addr  = m1_req_addr;
         w_sel_req.wen   = m1_req_wen;
         w_sel_req.wdata = m1_req_wdata;
         w_sel_req.wmask = m1_req_wmask;
         w_sel_req.size  = m1_req_size;
         w_sel_req.srcid = SRCID1;
      end else begin
         w_sel_req.addr  = m0_req_addr;
         w_sel_req.wen   = m0_req_wen;
         w_sel_req.wdata = m0_req_wdata;
         w_sel_req.wmask = m0_req_wmask;
         w_sel_req.size  = m0_req_size;
         w_sel_req.srcid = SRCID0;
      end
   end

   // ------------------------------------------------------------------
   // Issue FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      bus_req_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|w_grant) begin
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            bus_req_valid = 1'b1;
            // Handshake cycle never re-grants, so at most one request per two cycles
            if (bus_req_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Held request fields need no reset: they are only visible while valid
   always_ff @(posedge clk) begin
      if (|w_grant) begin
         r_req <= w_sel_req;
      end
   end

   assign bus_req_addr  = r_req.addr;
   assign bus_req_wen   = r_req.wen;
   assign bus_req_wdata = r_req.wdata;
   assign bus_req_wmask = r_req.wmask;
   assign bus_req_size  = r_req.size;
   assign bus_req_srcid = r_req.srcid;

   // ------------------------------------------------------------------
   // Response routing
   // ------------------------------------------------------------------
   assign w_hit0 = (bus_resp_dstid == SRCID0);
   assign w_hit1 = !w_hit0 && (bus_resp_dstid == SRCID1);

   assign m0_resp_valid = bus_resp_valid & w_hit0;
   assign m1_resp_valid = bus_resp_valid & w_hit1;
   assign m0_resp_rdata = bus_resp_rdata;
   assign m0_resp_ren   = bus_resp_ren;
   assign m0_resp_size  = bus_resp_size;
   assign m1_resp_rdata = bus_resp_rdata;
   assign m1_resp_ren   = bus_resp_ren;
   assign m1_resp_size  = bus_resp_size;

   // Unmatched responses are accepted and dropped so the bus cannot stall
   always_comb begin
      bus_resp_ready = 1'b1;
      if (rst) begin
         bus_resp_ready = 1'b0;
      end else if (w_hit0) begin
         bus_resp_ready = m0_resp_ready;
      end else if (w_hit1) begin
         bus_resp_ready = m1_resp_ready;
      end
   end

   assign w_resp_hs  = bus_resp_valid & bus_resp_ready;
   assign w_resp_clr = {w_resp_hs & w_hit1, w_resp_hs & w_hit0};
   assign w_resp_bad = w_resp_hs & ~w_hit0 & ~w_hit1;

   // ------------------------------------------------------------------
   // Pending, last-grant and error state
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend       <= 2'b00;
         r_last_grant <= 1'b1;
         r_err_dstid  <= 1'b0;
      end else begin
         r_pend <= (r_pend & ~w_resp_clr) | w_grant;
         if (|w_grant) begin
            r_last_grant <= w_arb_idx;
         end
         if (w_resp_bad) begin
            r_err_dstid <= 1'b1;
         end
      end
   end

   assign err_dstid = r_err_dstid;

endmodule
`default_nettype wire
